// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, result on a done pulse.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that selects a - b instead of a + b + Cin.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, done_q;

    logic             load_en, shift_en, fin_en;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        load_en  = (state_q == IDLE) && start;
        shift_en = (state_q == RUN);
        fin_en   = (state_q == DONE);
    end

    // Subtraction is a + ~b + 1; Cin is ignored in that mode.
    always_comb begin
        b_load = b;
        c_load = Cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin_en;
            if (load_en) begin
                a_sh_q  <= a;
                b_sh_q  <= b_load;
                carry_q <= c_load;
                cnt_q   <= '0;
            end else if (shift_en) begin
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                res_q   <= {fa_sum(a_sh_q[0], b_sh_q[0], carry_q), res_q[WIDTH-1:1]};
                carry_q <= fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
                a_sh_q  <= a_sh_q >> 1;
                b_sh_q  <= b_sh_q >> 1;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (fin_en) begin
                sum_q  <= res_q;
                cout_q <= carry_q;
            end
        end
    end

    assign done = done_q;
    assign sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): transaction-level reference model plus directed cases.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         Cin;
    logic         busy, done, Cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_v = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_v),
`endif
        .a     (a),
        .b     (b),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: an accepted request yields a + b + Cin exactly W+1 edges later.
    int           phase = 0;
    logic [W:0]   pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (phase == 0) begin
                if (start) begin
                    pend  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, Cin};
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub_v) pend <= {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`endif
                    phase <= 1;
                end
            end else if (phase == W + 1) begin
                m_sum  <= pend[W-1:0];
                m_cout <= pend[W];
                m_done <= 1'b1;
                phase  <= 0;
            end else begin
                phase <= phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model busy", 32'(busy), 32'(phase != 0));
            chk("model done", 32'(done), 32'(m_done));
            chk("model sum", 32'(sum), 32'(m_sum));
            chk("model Cout", 32'(Cout), 32'(m_cout));
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input string nm);
        int busy_n = 0;
        int done_k = 0;
        @(negedge clk);
        a = ta; b = tb_v; Cin = tc; start = 1'b1;
        for (int k = 1; k <= W + 6 && done_k == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom); Cin = 1'($urandom);
            if (busy) busy_n++;
            if (done) done_k = k;
        end
        chk({nm, " done_at"}, 32'(done_k), 32'(W + 2));
        chk({nm, " busy_cycles"}, 32'(busy_n), 32'(W + 1));
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " Cout"}, 32'(Cout), 32'(ec));
    endtask

    initial begin
        int done_n;
        int last_k;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset Cout", 32'(Cout), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "0F+01");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF+FF+1");

        // start pulsed again mid-run must be ignored
        @(negedge clk);
        a = 8'h01; b = 8'h01; Cin = 1'b0; start = 1'b1;
        done_n = 0;
        for (int k = 1; k <= 2 * W + 8; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (k == 3) a = 8'hAA;
            if (done) done_n++;
        end
        start = 1'b0;
        chk("ignore_start done_count", 32'(done_n), 32'd1);
        chk("ignore_start sum", 32'(sum), 32'h02);
        chk("ignore_start Cout", 32'(Cout), 32'd0);

        // reset during RUN aborts immediately
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "pre_reset");
        @(negedge clk);
        a = 8'h01; b = 8'h01; Cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort Cout", 32'(Cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "03+04");

        // start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        a = 8'h10; b = 8'h20; Cin = 1'b0; start = 1'b1;
        done_n = 0; last_k = 0;
        for (int k = 1; k <= 4 * (W + 2) + 2; k++) begin
            @(negedge clk);
            if (done) begin
                chk("hold done spacing", 32'(k - last_k), 32'(W + 2));
                chk("hold sum", 32'(sum), (done_n % 2 == 0) ? 32'h30 : 32'h00);
                chk("hold Cout", 32'(Cout), (done_n % 2 == 0) ? 32'd0 : 32'd1);
                last_k = k;
                done_n++;
            end
            if (((k / (W + 2)) % 2) == 0) begin
                a = 8'h10; b = 8'h20;
            end else begin
                a = 8'h80; b = 8'h80;
            end
            start = (k <= 3 * (W + 2) + 1);
        end
        start = 1'b0;
        chk("hold done_count", 32'(done_n), 32'd4);

`ifdef SERIAL_ADDER_SUB_EN
        sub_v = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, "05-07");
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "07-05");
        sub_v = 1'b0;
`endif

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            a = 8'($urandom); b = 8'($urandom); Cin = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
`ifdef SERIAL_ADDER_SUB_EN
            sub_v = 1'($urandom);
`endif
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request a new addition; sampled on clk rising edge.
REQ-005 Port: a  input  WIDTH  operand A; sampled only in the cycle start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; sampled only in the cycle start is accepted.
REQ-007 Port: Cin  input  1  carry-in; sampled only in the cycle start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  single-cycle pulse when sum/Cout are updated.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Port: Cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute {Cout,sum} = a + b + Cin bit-serially: one full-adder bit per clock, LSB first, with a registered carry between bits.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch a, b and Cin into internal shift registers and the carry flop, clear the bit counter, and enter RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each cycle SHALL add bit 0 of the shifted A/B with the carry flop, shift the sum bit into the result MSB, update the carry flop, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit it SHALL enter DONE.
REQ-017 DONE: for one cycle, done=1, sum and Cout are loaded from the result register and carry flop; the next state SHALL be IDLE.
REQ-018 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH+1 (WIDTH=8: done visible after edge 9).
REQ-020 start asserted in RUN or DONE SHALL be ignored; no queuing, and operands are not resampled.
REQ-021 sum and Cout SHALL hold their values between done pulses; changes to a/b/Cin outside acceptance SHALL have no effect.
REQ-022 Carry out of the MSB SHALL appear on Cout; sum SHALL wrap modulo 2^WIDTH.
REQ-023 Holding start high continuously SHALL start a new addition on the first IDLE cycle after each DONE (one result every WIDTH+2 cycles).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, Cout=0, and clear the counter, carry flop and shift registers.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN: when defined, an extra port sub (input, 1) SHALL exist and be sampled with start.
REQ-027 With SERIAL_ADDER_SUB_EN and sub=1, the block SHALL latch ~b, force the initial carry to 1 and ignore Cin, giving sum = a - b mod 2^WIDTH and Cout = 1 when no borrow occurs.
REQ-028 Without SERIAL_ADDER_SUB_EN, the sub port SHALL be absent and behaviour SHALL be addition only, as in REQ-012.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, Cin=0, 1-cycle start -> busy high for 9 cycles; done pulse after edge 9; sum=0x10, Cout=0.
REQ-030 a=0xFF, b=0x01, Cin=0 -> sum=0x00, Cout=1; a=0xFF, b=0xFF, Cin=1 -> sum=0xFF, Cout=1.
REQ-031 Start 0x01+0x01; pulse start with a=0xAA at RUN cycle 3 -> single done, sum=0x02, Cout=0.
REQ-032 rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; then 0x03+0x04 -> sum=0x07.
REQ-033 start held high, alternating operands 0x10+0x20 and 0x80+0x80 -> done pulses exactly 10 cycles apart; sum=0x30/Cout=0, then sum=0x00/Cout=1.
REQ-034 With SERIAL_ADDER_SUB_EN, sub=1: 0x05-0x07 -> sum=0xFE, Cout=0; 0x07-0x05 -> sum=0x02, Cout=1.
